// File: rtl/gprf_write_arbiter.sv
// gprf_write_arbiter
// -----------------------------------------------------------------------------
// Sequencer and arbiter for the single write port of the 32x32 general-purpose
// register file. After reset it optionally sweeps $1..$31 to zero. It then
// shares the write port between the ALU writeback (A) and the load writeback
// (B) using valid/ready handshakes and round-robin arbitration.
//
// Build option:
//   GPRF_ARB_CLEAR_EN  defined   -> CLEAR state with the zeroing sweep exists.
//                      undefined -> reset goes straight to RUN; init_done is 1
//                                   from the first cycle after reset.
//
// Ports:
//   clk            single clock, rising-edge state updates
//   rst            synchronous, active-high reset
//   a_valid/a_addr/a_data/a_ready  ALU writeback request (a_ready combinational)
//   b_valid/b_addr/b_data/b_ready  load writeback request (b_ready combinational)
//   address_W      register file write address (registered)
//   write_data     register file write data (registered)
//   write_enable   register file write strobe (registered)
//   init_done      high once the clear sweep has finished (registered)
// -----------------------------------------------------------------------------
module gprf_write_arbiter #(
    parameter int NREQ_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [NREQ_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [NREQ_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [NREQ_W-1:0] address_W,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic              init_done
);

    // Round-robin pointer encoding: who won the most recent grant.
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

`ifdef GPRF_ARB_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [NREQ_W-1:0] clr_ptr_r;
    logic [NREQ_W-1:0] clr_ptr_nxt_s;
`endif

    logic              run_s;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              last_r;
    logic              last_nxt_s;
    logic [NREQ_W-1:0] addr_r;
    logic [NREQ_W-1:0] addr_nxt_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_nxt_s;
    logic              we_r;
    logic              we_nxt_s;
    logic              init_r;
    logic              init_nxt_s;

`ifdef GPRF_ARB_CLEAR_EN
    assign run_s = (state_r == ST_RUN);
`else
    assign run_s = 1'b1;
`endif

    // Round-robin choice between the two requesters. Grants are withheld while
    // rst is high so that nothing is accepted on a reset edge.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (run_s && !rst) begin
            if (a_valid && b_valid) begin
                if (last_r == LAST_B) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
            end else begin
                grant_a_s = a_valid;
                grant_b_s = b_valid;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign a_ready = grant_a_s;
    assign b_ready = grant_b_s;

    // Next value of the write port, round-robin pointer and sweep state.
    always_comb begin
        we_nxt_s   = 1'b0;
        addr_nxt_s = addr_r;
        data_nxt_s = data_r;
        last_nxt_s = last_r;
        init_nxt_s = init_r;
`ifdef GPRF_ARB_CLEAR_EN
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
`endif
        // A write to $0 still completes the handshake but never strobes.
        if (grant_a_s) begin
            addr_nxt_s = a_addr;
            data_nxt_s = a_data;
            we_nxt_s   = (a_addr != {NREQ_W{1'b0}});
            last_nxt_s = LAST_A;
        end else if (grant_b_s) begin
            addr_nxt_s = b_addr;
            data_nxt_s = b_data;
            we_nxt_s   = (b_addr != {NREQ_W{1'b0}});
            last_nxt_s = LAST_B;
        end else begin
            we_nxt_s = 1'b0;
        end
`ifdef GPRF_ARB_CLEAR_EN
        // During the sweep no grant can be active, so the sweep owns the port.
        case (state_r)
            ST_CLEAR: begin
                we_nxt_s      = 1'b1;
                addr_nxt_s    = clr_ptr_r;
                data_nxt_s    = {DATA_W{1'b0}};
                clr_ptr_nxt_s = clr_ptr_r + {{(NREQ_W-1){1'b0}}, 1'b1};
                if (clr_ptr_r == {NREQ_W{1'b1}}) begin
                    state_nxt_s = ST_RUN;
                    init_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_CLEAR;
            end
        endcase
`endif
    end

    // Register the write port, pointer and sweep state; reset drops any
    // in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r   <= 1'b0;
            addr_r <= {NREQ_W{1'b0}};
            data_r <= {DATA_W{1'b0}};
            last_r <= LAST_B;
`ifdef GPRF_ARB_CLEAR_EN
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {{(NREQ_W-1){1'b0}}, 1'b1};
            init_r    <= 1'b0;
`else
            init_r    <= 1'b1;
`endif
        end else begin
            we_r   <= we_nxt_s;
            addr_r <= addr_nxt_s;
            data_r <= data_nxt_s;
            last_r <= last_nxt_s;
            init_r <= init_nxt_s;
`ifdef GPRF_ARB_CLEAR_EN
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
`endif
        end
    end

    assign address_W    = addr_r;
    assign write_data   = data_r;
    assign write_enable = we_r;
    assign init_done    = init_r;

endmodule

// File: tb/tb_gprf_write_arbiter.sv
// Self-checking bench for gprf_write_arbiter: directed scenarios plus
// randomized two-requester traffic against a behavioural model, with a small
// register file driven by the DUT's write port.
module tb_gprf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic [4:0]  address_W;
    logic [31:0] write_data;
    logic        write_enable;
    logic        init_done;

    gprf_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .address_W(address_W), .write_data(write_data),
        .write_enable(write_enable), .init_done(init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench register file fed by the DUT's write port.
    logic [31:0] rf [32];
    logic        rf_clr;
    logic        rf_arm;
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    // Register file commit: clear, preload, or the DUT's write.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (pl_en) begin
            rf[pl_addr] <= pl_data;
        end else if (rf_arm && write_enable && address_W != 5'd0) begin
            rf[address_W] <= write_data;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    bit          m_valid = 1'b0;
    bit          m_run;
    bit          m_last_b;
    bit          m_we;
    bit          m_init;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_sweep;
    logic [31:0] m_rf [32];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, act, exp, $time);
        end
    endfunction

    // Who may transfer this cycle, from the arbitration rules.
    function automatic void model_ready(output bit ra, output bit rb);
        ra = 1'b0;
        rb = 1'b0;
        if (m_run && !rst) begin
            if (a_valid && b_valid) begin
                ra = m_last_b;
                rb = !m_last_b;
            end else begin
                ra = a_valid;
                rb = b_valid;
            end
        end
    endfunction

    // Advance the model across one rising edge.
    function automatic void model_edge(input bit ra, input bit rb);
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (pl_en) begin
            m_rf[pl_addr] = pl_data;
        end else if (rf_arm && m_we && m_addr != 5'd0) begin
            m_rf[m_addr] = m_data;
        end
        if (rst) begin
            m_valid  = 1'b1;
            m_we     = 1'b0;
            m_addr   = 5'd0;
            m_data   = 32'd0;
            m_last_b = 1'b1;
`ifdef GPRF_ARB_CLEAR_EN
            m_run   = 1'b0;
            m_init  = 1'b0;
            m_sweep = 1;
`else
            m_run   = 1'b1;
            m_init  = 1'b1;
`endif
        end else if (!m_valid) begin
            m_valid = 1'b0;
        end else if (!m_run) begin
            m_we   = 1'b1;
            m_addr = m_sweep[4:0];
            m_data = 32'd0;
            if (m_sweep == 31) begin
                m_run  = 1'b1;
                m_init = 1'b1;
            end
            m_sweep++;
        end else if (ra) begin
            m_we = (a_addr != 5'd0); m_addr = a_addr; m_data = a_data; m_last_b = 1'b0;
        end else if (rb) begin
            m_we = (b_addr != 5'd0); m_addr = b_addr; m_data = b_data; m_last_b = 1'b1;
        end else begin
            m_we = 1'b0;
        end
    endfunction

    // One clock cycle: drive inputs, check readies, step model, check outputs.
    task automatic cycle(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                         output bit ga, output bit gb);
        bit ea, eb;
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        model_ready(ea, eb);
        if (m_valid) begin
            chk("a_ready", 32'(a_ready), 32'(ea));
            chk("b_ready", 32'(b_ready), 32'(eb));
        end
        ga = a_ready;
        gb = b_ready;
        model_edge(ea, eb);
        @(posedge clk);
        #1;
        if (m_valid) begin
            rf_arm = 1'b1;
            chk("write_enable", 32'(write_enable), 32'(m_we));
            chk("address_W", 32'(address_W), 32'(m_addr));
            chk("write_data", write_data, m_data);
            chk("init_done", 32'(init_done), 32'(m_init));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ga, gb, got, r;
        int          k_grant;
        bit          pa, pb;
        logic [4:0]  raa, rba;
        logic [31:0] rad, rbd, da, db;

        rst = 1'b1; a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        rf_clr = 1'b1; rf_arm = 1'b0; pl_en = 1'b0; pl_addr = 5'd0; pl_data = 32'd0;

        // Reset for two cycles, preloading $5 on the second.
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
        rf_clr = 1'b0;
        chk("reset_we", 32'(write_enable), 32'd0);
        chk("reset_addr", 32'(address_W), 32'd0);
        chk("reset_data", write_data, 32'd0);
`ifdef GPRF_ARB_CLEAR_EN
        chk("reset_init", 32'(init_done), 32'd0);
`else
        chk("reset_init", 32'(init_done), 32'd1);
`endif
        pl_en = 1'b1; pl_addr = 5'd5; pl_data = 32'hDEADBEEF;
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
        pl_en = 1'b0;

        // Sweep (if built) then the first single-requester write to $3.
        got = 1'b0;
        k_grant = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!got) begin
                cycle(1'b0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 32'd0, ga, gb);
`ifdef GPRF_ARB_CLEAR_EN
                if (k <= 31) begin
                    chk("sweep_addr", 32'(address_W), 32'(k));
                    chk("sweep_we", 32'(write_enable), 32'd1);
                    chk("sweep_ready", 32'(ga), 32'd0);
                    chk("sweep_init", 32'(init_done), 32'(k == 31));
                end
`endif
                if (ga) begin
                    got = 1'b1;
                    k_grant = k;
                end
            end
        end
`ifdef GPRF_ARB_CLEAR_EN
        chk("first_grant_cycle", 32'(k_grant), 32'd32);
`else
        chk("first_grant_cycle", 32'(k_grant), 32'd1);
`endif
        chk("a3_we", 32'(write_enable), 32'd1);
        chk("a3_addr", 32'(address_W), 32'd3);
        chk("a3_data", write_data, 32'h12345678);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
        chk("a3_rf", rf[3], 32'h12345678);
        chk("idle_we", 32'(write_enable), 32'd0);
        chk("idle_hold_addr", 32'(address_W), 32'd3);
`ifdef GPRF_ARB_CLEAR_EN
        chk("swept_rf5", rf[5], 32'd0);
`else
        chk("kept_rf5", rf[5], 32'hDEADBEEF);
`endif

        // Zero register: handshake completes, no strobe.
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, ga, gb);
        chk("zero_b_ready", 32'(gb), 32'd1);
        chk("zero_we", 32'(write_enable), 32'd0);
        chk("zero_addr", 32'(address_W), 32'd0);

        // Contention after a B win: A goes first, then alternate.
        da = 32'h1111;
        db = 32'h2222;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 5'd4, da, 1'b1, 5'd6, db, ga, gb);
            chk("cont_grant_a", 32'(ga), 32'((i % 2) == 0));
            chk("cont_grant_b", 32'(gb), 32'((i % 2) == 1));
            chk("cont_addr", 32'(address_W), ((i % 2) == 0) ? 32'd4 : 32'd6);
            if (ga) da = da + 32'd1;
            if (gb) db = db + 32'd1;
        end
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
        chk("cont_rf4", rf[4], 32'h1112);
        chk("cont_rf6", rf[6], 32'h2223);

        // Reset in the cycle A requests $7; the request is then withdrawn.
        cycle(1'b1, 1'b1, 5'd7, 32'hAB, 1'b0, 5'd0, 32'd0, ga, gb);
        chk("midrst_we", 32'(write_enable), 32'd0);
`ifdef GPRF_ARB_CLEAR_EN
        chk("midrst_init", 32'(init_done), 32'd0);
`else
        chk("midrst_init", 32'(init_done), 32'd1);
`endif
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
`ifdef GPRF_ARB_CLEAR_EN
        chk("restart_addr", 32'(address_W), 32'd1);
`endif
        for (int i = 0; i < 34; i++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
        end
        chk("midrst_rf7", rf[7], 32'd0);

        // Randomized traffic with occasional resets.
        pa = 1'b0; pb = 1'b0;
        raa = 5'd0; rba = 5'd0; rad = 32'd0; rbd = 32'd0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 199) == 0);
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1'b1; raa = 5'($urandom_range(0, 31)); rad = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1; rba = 5'($urandom_range(0, 31)); rbd = $urandom;
            end
            cycle(r, pa, raa, rad, pb, rba, rbd, ga, gb);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
        end
        for (int i = 0; i < 32; i++) begin
            chk("rf_final", rf[i], m_rf[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
